// File: rtl/multiplier_iter_param.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle; per-transaction signed/unsigned.
// Latency: out_valid rises WIDTH/STEP edges after the accept edge; one product per WIDTH/STEP+2 cycles.
// Backpressure: in_ready only in IDLE; the product holds in DONE until out_ready.
module multiplier_iter_param #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 sgn,
    output logic [2*WIDTH-1:0]   s,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;

    generate
        if (WIDTH < 4 || !(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || (WIDTH % STEP) != 0) begin : g_bad_param
            $error("multiplier_iter_param: illegal WIDTH/STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] xm_q, xm_d;
    logic [WIDTH-1:0] ym_q, ym_d;
    logic            neg_q, neg_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   s_q, s_d;
    logic            ov_q, ov_d;

    logic            last;
    logic [W2-1:0]   pp;
    logic [W2-1:0]   acc_sum;

    assign last    = (cnt_q == CW'(N - 1));
    // Partial product of |x| with the next STEP multiplier bits, aligned to their weight.
    assign pp      = ({{WIDTH{1'b0}}, xm_q} * {{(W2-STEP){1'b0}}, ym_q[STEP-1:0]}) << (STEP * cnt_q);
    assign acc_sum = acc_q + pp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            xm_q    <= '0;
            ym_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xm_d  = xm_q;
        ym_d  = ym_q;
        neg_d = neg_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        s_d   = s_q;
        ov_d  = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xm_d  = (sgn && x[WIDTH-1]) ? -x : x;
                    ym_d  = (sgn && y[WIDTH-1]) ? -y : y;
                    neg_d = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                ym_d  = ym_q >> STEP;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    s_d  = neg_q ? -acc_sum : acc_sum;
                    ov_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) ov_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        s         = s_q;
        out_valid = ov_q;
    end
endmodule

// File: tb/tb_multiplier_iter_param.sv
// Bench for multiplier_iter_param: a WIDTH=32/STEP=1 and a WIDTH=16/STEP=4 instance on one clock and reset.
module tb_multiplier_iter_param;
    logic        clk, rst;
    logic        iv32, ir32, sgn32, ov32, or32;
    logic [31:0] x32, y32;
    logic [63:0] s32;
    logic        iv16, ir16, sgn16, ov16, or16;
    logic [15:0] x16, y16;
    logic [31:0] s16;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [63:0] q32[$];
    logic [31:0] q16[$];

    multiplier_iter_param #(.WIDTH(32), .STEP(1)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x32), .y(y32),
        .sgn(sgn32), .s(s32), .out_valid(ov32), .out_ready(or32));

    multiplier_iter_param #(.WIDTH(16), .STEP(4)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
        .sgn(sgn16), .s(s16), .out_valid(ov16), .out_ready(or16));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sg);
        int sa, sb;
        if (sg) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        return 32'(a) * 32'(b);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        iv32 = 0; x32 = 0; y32 = 0; sgn32 = 0; or32 = 1;
        iv16 = 0; x16 = 0; y16 = 0; sgn16 = 0; or16 = 1;
        #3 rst = 1'b0;
        #1;
        total++; if (s32 !== 64'h0)   $display("FAIL reset_s32 got %h want 0", s32);  else passed++;
        total++; if (ov32 !== 1'b0)   $display("FAIL reset_ov32 got %b want 0", ov32); else passed++;
        total++; if (ir32 !== 1'b1)   $display("FAIL reset_ir32 got %b want 1", ir32); else passed++;
        total++; if (s16 !== 32'h0)   $display("FAIL reset_s16 got %h want 0", s16);  else passed++;
        total++; if (ov16 !== 1'b0)   $display("FAIL reset_ov16 got %b want 0", ov16); else passed++;
        total++; if (ir16 !== 1'b1)   $display("FAIL reset_ir16 got %b want 1", ir16); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic txn32(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] exp, input string name);
        int n;
        logic [63:0] e;
        q32.push_back(exp);
        @(negedge clk);
        or32 = 1; x32 = a; y32 = b; sgn32 = sg; iv32 = 1;
        n = 0;
        while (!ir32 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        iv32 = 0; x32 = $urandom; y32 = $urandom; sgn32 = 1'($urandom);
        n = 0;
        while (!ov32 && n < 200) begin @(posedge clk); n++; @(negedge clk); end
        total++; if (n !== 32) $display("FAIL %s_latency got %0d want 32", name, n); else passed++;
        e = q32.pop_front();
        total++; if (s32 !== e) $display("FAIL %s_product got %h want %h", name, s32, e); else passed++;
        @(negedge clk);
        total++; if (ov32 !== 1'b0) $display("FAIL %s_ov_drop got %b want 0", name, ov32); else passed++;
    endtask

    task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         input logic [31:0] exp, input string name);
        int n;
        logic [31:0] e;
        q16.push_back(exp);
        @(negedge clk);
        or16 = 1; x16 = a; y16 = b; sgn16 = sg; iv16 = 1;
        n = 0;
        while (!ir16 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        iv16 = 0; x16 = 16'($urandom); y16 = 16'($urandom);
        n = 0;
        while (!ov16 && n < 100) begin @(posedge clk); n++; @(negedge clk); end
        total++; if (n !== 4) $display("FAIL %s_latency got %0d want 4", name, n); else passed++;
        e = q16.pop_front();
        total++; if (s16 !== e) $display("FAIL %s_product got %h want %h", name, s16, e); else passed++;
    endtask

    task automatic test_signed_ones;
        txn32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, "neg1_sq");
    endtask

    task automatic test_unsigned_vs_signed;
        txn32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "umax_sq");
        txn32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, "umax_as_signed");
    endtask

    task automatic test_most_negative;
        txn32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "minneg_sq");
        txn32(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, "minneg_x1");
    endtask

    task automatic test_zero;
        txn32(32'h0, 32'd12345, 1'b1, 64'h0, "zero_op");
    endtask

    task automatic test_hold_done;
        int n;
        logic [63:0] e;
        q32.push_back(64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);
        or32 = 0; x32 = 32'd3; y32 = 32'hFFFFFFFB; sgn32 = 1; iv32 = 1;
        @(posedge clk);
        @(negedge clk);
        iv32 = 0;
        n = 0;
        while (!ov32 && n < 200) begin @(negedge clk); n++; end
        e = q32.pop_front();
        q32.push_back(64'd63);
        for (int i = 0; i < 10; i++) begin
            iv32 = 1; x32 = 32'd7; y32 = 32'd9; sgn32 = 0;
            @(posedge clk);
            @(negedge clk);
            total++; if (s32 !== e)    $display("FAIL hold_s c%0d got %h want %h", i, s32, e); else passed++;
            total++; if (ov32 !== 1'b1) $display("FAIL hold_ov c%0d got %b want 1", i, ov32); else passed++;
            total++; if (ir32 !== 1'b0) $display("FAIL hold_ir c%0d got %b want 0", i, ir32); else passed++;
        end
        or32 = 1;
        @(posedge clk);
        @(negedge clk);
        total++; if (ov32 !== 1'b0) $display("FAIL release_ov got %b want 0", ov32); else passed++;
        total++; if (ir32 !== 1'b1) $display("FAIL release_ir got %b want 1", ir32); else passed++;
        @(posedge clk);
        @(negedge clk);
        total++; if (ir32 !== 1'b0) $display("FAIL next_accept_ir got %b want 0", ir32); else passed++;
        iv32 = 0; x32 = $urandom; y32 = $urandom;
        n = 0;
        while (!ov32 && n < 200) begin @(posedge clk); n++; @(negedge clk); end
        total++; if (n !== 32) $display("FAIL held_next_latency got %0d want 32", n); else passed++;
        e = q32.pop_front();
        total++; if (s32 !== e) $display("FAIL held_next_product got %h want %h", s32, e); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random16(input int ntx, input bit bp);
        logic [31:0] e;
        int acc_cyc[$];
        int sent, got, guard_d, guard_m, last_rise, a;
        bit prev_ov;
        sent = 0; got = 0; guard_d = 0; guard_m = 0; last_rise = -1; prev_ov = 0;
        fork
            begin
                while (sent < ntx && guard_d < ntx * 20 + 100) begin
                    @(negedge clk);
                    guard_d++;
                    if (ir16) begin
                        x16 = 16'($urandom); y16 = 16'($urandom); sgn16 = 1'($urandom);
                        iv16 = 1;
                        q16.push_back(ref16(x16, y16, sgn16));
                        acc_cyc.push_back(cyc + 1);
                        sent++;
                    end
                end
                @(negedge clk);
                iv16 = 0;
            end
            begin
                while (got < ntx && guard_m < ntx * 20 + 100) begin
                    @(negedge clk);
                    guard_m++;
                    or16 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (ov16 && !prev_ov) begin
                        a = (acc_cyc.size() > 0) ? acc_cyc.pop_front() : -100;
                        total++; if (cyc - a !== 4) $display("FAIL rnd_latency got %0d want 4", cyc - a); else passed++;
                        if (!bp && last_rise >= 0) begin
                            total++; if (cyc - last_rise !== 6) $display("FAIL rnd_interval got %0d want 6", cyc - last_rise); else passed++;
                        end
                        last_rise = cyc;
                    end
                    prev_ov = ov16;
                    if (ov16 && or16) begin
                        e = (q16.size() > 0) ? q16.pop_front() : 32'hDEADBEEF;
                        total++; if (s16 !== e) $display("FAIL rnd_product got %h want %h", s16, e); else passed++;
                        got++;
                    end
                end
                total++; if (got !== ntx) $display("FAIL rnd_count got %0d want %0d", got, ntx); else passed++;
                or16 = 1;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy;
        bit seen;
        @(negedge clk);
        or16 = 1; x16 = 16'h1234; y16 = 16'h0567; sgn16 = 0; iv16 = 1;
        @(posedge clk);
        @(negedge clk);
        iv16 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (ov16 !== 1'b0) $display("FAIL midrst_ov got %b want 0", ov16); else passed++;
        total++; if (ir16 !== 1'b1) $display("FAIL midrst_ir got %b want 1", ir16); else passed++;
        total++; if (s32 !== 64'h0) $display("FAIL midrst_s32 got %h want 0", s32); else passed++;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov16) seen = 1;
        end
        total++; if (seen !== 1'b0) $display("FAIL midrst_no_pulse got %b want 0", seen); else passed++;
        txn16(16'hFFF9, 16'd300, 1'b1, 32'hFFFFF7CC, "post_rst");
    endtask

    initial begin
        test_reset();
        test_signed_ones();
        test_unsigned_vs_signed();
        test_most_negative();
        test_zero();
        test_hold_done();
        txn16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_minneg_sq");
        test_random16(1500, 1'b0);
        test_random16(1000, 1'b1);
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
